zebra_frame_binarizer: RTL and testbench
========================================

Name: zebra_frame_binarizer

Overview:
- Upstream stage of zebra_crossing_detector. Accepts a raster grayscale pixel stream and thresholds each pixel to a 2-bit code (0=black, 1=white).
- Writes the codes into the shared frame BRAM, then pulses the detector's valid_to_read.
- Holds off the next frame until the detector reports detection_valid. This keeps the detector's visited marks from being overwritten mid-scan.

Parameters:
- IMG_WIDTH, 640, pixels per line
- IMG_HEIGHT, 480, lines per frame
- PIX_W, 8, grayscale pixel width
- ADDR_W, $clog2(IMG_WIDTH*IMG_HEIGHT), BRAM address width (derived; do not override)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- threshold  in  PIX_W  white threshold, sampled at start of frame
- s_valid  in  1  pixel valid
- s_ready  out  1  pixel accepted when s_valid && s_ready
- s_data  in  PIX_W  grayscale pixel
- s_sof  in  1  marks first pixel of frame (qualified by handshake)
- s_eol  in  1  marks last pixel of line (qualified by handshake)
- bram_we  out  1  BRAM write enable
- bram_waddr  out  ADDR_W  BRAM write address, y*IMG_WIDTH+x
- bram_wdata  out  2  2'b01 if pixel >= threshold else 2'b00
- frame_ready  out  1  one-cycle pulse, drives detector valid_to_read
- detection_valid  in  1  detector done pulse
- busy  out  1  high in FILL, HANDOFF, WAIT_DET
- frame_err  out  1  one-cycle pulse on framing error

Behaviour:
- Reset values: s_ready=0, bram_we=0, bram_waddr=0, bram_wdata=0, frame_ready=0, busy=0, frame_err=0. State=IDLE, x/y counters=0, thr_q=0.
- State IDLE:
  - s_ready=1.
  - Accepted beats without s_sof are dropped with no write.
  - An accepted beat with s_sof latches thr_q=threshold, writes pixel 0 at address 0, sets x=1, y=0, and goes to FILL.
  - If IMG_WIDTH==1, an sof beat must also carry eol.
- State FILL:
  - s_ready=1. Each accepted beat writes bram_wdata=(s_data>=thr_q)?01:00 at address y*IMG_WIDTH+x.
  - The address is kept as a running counter (+1 per beat); no multiply.
  - Write latency: bram_we/waddr/wdata are registered and appear the cycle after the handshake, for one cycle per beat.
  - Comparison is unsigned and uses thr_q. Changing threshold mid-frame has no effect.
  - x wraps to 0 and y increments when x==IMG_WIDTH-1.
- Framing checks in FILL:
  - s_eol must be asserted exactly when x==IMG_WIDTH-1.
  - On an eol mismatch: pulse frame_err, suppress that beat's write, go to IDLE.
  - s_sof on a beat in FILL: pulse frame_err, treat the beat as a new frame start (address 0, relatch thr_q), stay in FILL.
- End of frame: the beat with x==IMG_WIDTH-1, y==IMG_HEIGHT-1 and eol is written, then the FSM goes to HANDOFF.
- State HANDOFF: s_ready=0. frame_ready=1 for exactly one cycle, on the cycle after the last write. Then go to WAIT_DET.
- State WAIT_DET:
  - s_ready=0. Wait for detection_valid=1, then go to IDLE the next cycle.
  - detection_valid in any other state is ignored.
- Simultaneous events: a handshake and a framing error on the same beat give an error pulse and no write.
- Reset mid-operation:
  - Returns to IDLE with all outputs at reset values on the next edge.
  - A partially written frame is abandoned; no frame_ready is issued.
  - No BRAM clearing is needed, because the next frame overwrites every address including visited (2'b10) marks.
- Arithmetic widths:
  - x uses $clog2(IMG_WIDTH) bits, y uses $clog2(IMG_HEIGHT) bits, address uses ADDR_W bits.
  - No counter may exceed IMG_WIDTH*IMG_HEIGHT-1.

Decomposition:
- Shared package zebra_pkg holds:
  - pixel code constants PIX_BLACK=2'b00, PIX_WHITE=2'b01, PIX_VISITED=2'b10, shared with zebra_crossing_detector;
  - the binarizer state enum (IDLE, FILL, HANDOFF, WAIT_DET).
- One sub-module is natural: raster_counter (x/y/address counters with wrap and end-of-line/end-of-frame flags), reusable by other stream stages.

Test Plan:
- 4x3 image, threshold=128, pixels 0..11 scaled ×20 with correct sof/eol:
  - 12 writes at addresses 0..11;
  - data 00 for pixels 0..6 (0..120), 01 for pixels 7..11 (140..220);
  - frame_ready pulses once, 1 cycle after the last write;
  - s_ready=0 until detection_valid is pulsed.
- Threshold changed from 128 to 0 mid-frame: all remaining writes still use 128.
- eol asserted at x=2 of a 4-wide line: frame_err pulse, no write for that beat, return to IDLE, no frame_ready.
- s_sof on pixel 5: frame_err pulse, next write at address 0, full frame then completes normally.
- Beats without sof in IDLE and during WAIT_DET: IDLE beats are dropped with no writes; WAIT_DET holds s_ready=0. After detection_valid, the next sof frame writes from address 0.
- rst_n low for 1 cycle mid-frame at pixel 6: outputs return to reset values, no frame_ready; the following complete frame is processed correctly.

Source files
------------

// File: rtl/zebra_pkg.sv
// Shared zebra types: pixel codes, binarizer FSM states, width helper.
// No ports; imported by the binarizer, its raster counter and the detector.
package zebra_pkg;

  localparam logic [1:0] PIX_BLACK   = 2'b00;
  localparam logic [1:0] PIX_WHITE   = 2'b01;
  localparam logic [1:0] PIX_VISITED = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HANDOFF,
    WAIT_DET
  } bin_state_e;

  // Counter width that stays legal for a dimension of 1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zebra_frame_binarizer_raster_counter.sv
// Raster x/y/address tracker for a pixel stream stage.
// Ports: clk/rst_n, i_clr, i_first, i_adv in; o_addr, o_eol, o_eof out.
module raster_counter
  import zebra_pkg::*;
#(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned AW     = cnt_w(WIDTH * HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_first,
  input  logic          i_adv,
  output logic [AW-1:0] o_addr,
  output logic          o_eol,
  output logic          o_eof
);

  localparam int unsigned XW = cnt_w(WIDTH);
  localparam int unsigned YW = cnt_w(HEIGHT);

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [AW-1:0] r_addr;

  logic [XW-1:0] w_bx;
  logic [YW-1:0] w_by;
  logic [AW-1:0] w_ba;
  logic          w_b_eol;
  logic          w_b_eof;

  logic [XW-1:0] w_nx;
  logic [YW-1:0] w_ny;
  logic [AW-1:0] w_na;

  // i_first steps from the origin: the beat itself sits at (0,0).
  assign w_bx = i_first ? '0 : r_x;
  assign w_by = i_first ? '0 : r_y;
  assign w_ba = i_first ? '0 : r_addr;

  assign w_b_eol = (w_bx == X_LAST);
  assign w_b_eof = w_b_eol && (w_by == Y_LAST);

  always_comb begin
    w_nx = w_bx + XW'(1);
    w_ny = w_by;
    w_na = w_ba + AW'(1);
    if (w_b_eol) begin
      w_nx = '0;
      w_ny = w_by + YW'(1);
    end
    if (w_b_eof) begin
      w_ny = '0;
      w_na = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (i_first || i_adv) begin
      r_x    <= w_nx;
      r_y    <= w_ny;
      r_addr <= w_na;
    end else if (i_clr) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end
  end

  assign o_addr = r_addr;
  assign o_eol  = (r_x == X_LAST);
  assign o_eof  = o_eol && (r_y == Y_LAST);

endmodule

// File: rtl/zebra_frame_binarizer.sv
// Thresholds a raster gray stream into 2-bit codes in the frame BRAM.
// Ports: s_* stream in, bram_* write out, frame_ready/detection_valid hs.
module zebra_frame_binarizer
  import zebra_pkg::*;
#(
  parameter  int unsigned IMG_WIDTH  = 640,
  parameter  int unsigned IMG_HEIGHT = 480,
  parameter  int unsigned PIX_W      = 8,
  localparam int unsigned ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PIX_W-1:0]  threshold,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PIX_W-1:0]  s_data,
  input  logic              s_sof,
  input  logic              s_eol,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_waddr,
  output logic [1:0]        bram_wdata,
  output logic              frame_ready,
  input  logic              detection_valid,
  output logic              busy,
  output logic              frame_err
);

  // Flags of the (0,0) position, used by sof beats.
  localparam logic SOF_EOL = (IMG_WIDTH == 1);
  localparam logic SOF_EOF = (IMG_WIDTH == 1) && (IMG_HEIGHT == 1);

  bin_state_e        r_state;
  logic [PIX_W-1:0]  r_thr;
  logic              r_s_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [1:0]        r_wdata;
  logic              r_fr;
  logic              r_busy;
  logic              r_err;

  logic              w_hs;
  logic              w_accepting;
  logic              w_sof_ok;
  logic              w_fill_ok;
  logic              w_white_new;
  logic              w_white;
  logic [ADDR_W-1:0] w_addr;
  logic              w_eol;
  logic              w_eof;

  assign w_hs        = s_valid && r_s_ready;
  assign w_accepting = (r_state == IDLE) || (r_state == FILL);

  // A well-framed frame start, from IDLE or restarting from FILL.
  assign w_sof_ok  = w_hs && w_accepting && s_sof &&
                     (s_eol == SOF_EOL);
  assign w_fill_ok = w_hs && (r_state == FILL) && !s_sof &&
                     (s_eol == w_eol);

  // Frame start beats compare against the threshold being latched.
  assign w_white_new = (s_data >= threshold);
  assign w_white     = (s_data >= r_thr);

  raster_counter #(
    .WIDTH  (IMG_WIDTH),
    .HEIGHT (IMG_HEIGHT),
    .AW     (ADDR_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (r_state != FILL),
    .i_first (w_sof_ok),
    .i_adv   (w_fill_ok),
    .o_addr  (w_addr),
    .o_eol   (w_eol),
    .o_eof   (w_eof)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_thr     <= '0;
      r_s_ready <= 1'b0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= PIX_BLACK;
      r_fr      <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_we  <= 1'b0;
      r_fr  <= 1'b0;
      r_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_s_ready <= 1'b1;
          if (w_sof_ok) begin
            r_thr   <= threshold;
            r_we    <= 1'b1;
            r_waddr <= '0;
            r_wdata <= w_white_new ? PIX_WHITE : PIX_BLACK;
            r_busy  <= 1'b1;
            if (SOF_EOF) begin
              r_state   <= HANDOFF;
              r_s_ready <= 1'b0;
            end else begin
              r_state <= FILL;
            end
          end else if (w_hs && s_sof) begin
            r_err <= 1'b1;
          end
        end
        FILL: begin
          if (w_hs) begin
            if (s_sof) r_err <= 1'b1;
            if (w_sof_ok) begin
              r_thr   <= threshold;
              r_we    <= 1'b1;
              r_waddr <= '0;
              r_wdata <= w_white_new ? PIX_WHITE : PIX_BLACK;
              if (SOF_EOF) begin
                r_state   <= HANDOFF;
                r_s_ready <= 1'b0;
              end
            end else if (w_fill_ok) begin
              r_we    <= 1'b1;
              r_waddr <= w_addr;
              r_wdata <= w_white ? PIX_WHITE : PIX_BLACK;
              if (w_eof) begin
                r_state   <= HANDOFF;
                r_s_ready <= 1'b0;
              end
            end else begin
              r_err   <= 1'b1;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        HANDOFF: begin
          r_fr    <= 1'b1;
          r_state <= WAIT_DET;
        end
        WAIT_DET: begin
          if (detection_valid) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_s_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  assign s_ready     = r_s_ready;
  assign bram_we     = r_we;
  assign bram_waddr  = r_waddr;
  assign bram_wdata  = r_wdata;
  assign frame_ready = r_fr;
  assign busy        = r_busy;
  assign frame_err   = r_err;

endmodule

// File: tb/tb_zebra_frame_binarizer.sv
// Randomized self-checking bench for zebra_frame_binarizer (4x3 image).
// Reference model tracks pixel index, latched threshold and expected writes.
module tb_zebra_frame_binarizer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    threshold = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    s_data = '0;
  logic          s_sof = 1'b0;
  logic          s_eol = 1'b0;
  logic          bram_we;
  logic [AW-1:0] bram_waddr;
  logic [1:0]    bram_wdata;
  logic          frame_ready;
  logic          detection_valid = 1'b0;
  logic          busy;
  logic          frame_err;

  always #5 clk = ~clk;

  zebra_frame_binarizer #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .PIX_W      (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .threshold       (threshold),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .s_sof           (s_sof),
    .s_eol           (s_eol),
    .bram_we         (bram_we),
    .bram_waddr      (bram_waddr),
    .bram_wdata      (bram_wdata),
    .frame_ready     (frame_ready),
    .detection_valid (detection_valid),
    .busy            (busy),
    .frame_err       (frame_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: 0 = waiting for sof, 1 = filling, 2 = frame handed off.
  int m_mode = 0;
  int m_p    = 0;
  int m_thr  = 0;
  int q_addr[$];
  int q_data[$];
  bit q_last[$];
  bit err_due = 0;
  bit fr_due  = 0;

  always @(negedge clk) begin
    chk("frame_err", frame_err, err_due);
    err_due = 0;
    chk("frame_ready", frame_ready, fr_due);
    fr_due = 0;
    if (bram_we) begin
      if (q_addr.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        chk("waddr", bram_waddr, q_addr.pop_front());
        chk("wdata", bram_wdata, q_data.pop_front());
        fr_due = q_last.pop_front();
      end
    end else if (q_addr.size() != 0) begin
      chk("missing_write", 0, 1);
      void'(q_addr.pop_front());
      void'(q_data.pop_front());
      void'(q_last.pop_front());
    end
  end

  task automatic model_beat(input int d, input bit sof, input bit eol);
    int pos;
    if (m_mode == 2) return;
    if (m_mode == 0 && !sof) return;
    pos = sof ? 0 : m_p;
    if (eol != ((pos % W) == W - 1)) begin
      err_due = 1;
      m_mode  = 0;
      return;
    end
    if (m_mode == 1 && sof) err_due = 1;
    if (sof) m_thr = int'(threshold);
    q_addr.push_back(pos);
    q_data.push_back((d >= m_thr) ? 1 : 0);
    q_last.push_back(pos == N - 1);
    m_p    = pos + 1;
    m_mode = (pos == N - 1) ? 2 : 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input int d, input bit sof, input bit eol);
    bit acc;
    s_valid = 1'b1;
    s_data  = d[7:0];
    s_sof   = sof;
    s_eol   = eol;
    acc     = s_ready;
    chk("s_ready", s_ready, m_mode != 2);
    chk("busy", busy, m_mode != 0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
    if (acc) model_beat(d, sof, eol);
  endtask

  task automatic send_px(input int p, input int d, input bit sof,
                         input bit eol_flip);
    beat(d, sof, ((p % W) == W - 1) ^ eol_flip);
  endtask

  task automatic det();
    detection_valid = 1'b1;
    @(posedge clk);
    #1;
    detection_valid = 1'b0;
    if (m_mode == 2) m_mode = 0;
  endtask

  task automatic finish_frame();
    idle(3);
    beat(77, 0, 0);
    beat(99, 1, 0);
    det();
    idle(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_we", bram_we, 0);
    chk("rst_waddr", bram_waddr, 0);
    chk("rst_wdata", bram_wdata, 0);
    chk("rst_frame_ready", frame_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    m_mode = 0;
    m_p    = 0;
    q_addr.delete();
    q_data.delete();
    q_last.delete();
    err_due = 0;
    fr_due  = 0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic full_frame(input int thr);
    threshold = 8'(thr);
    for (int p = 0; p < N; p++) send_px(p, p * 20, p == 0, 0);
  endtask

  task automatic rand_frame();
    int  kind;
    int  pos;
    int  p;
    int  d;
    bit  injected;
    bit  stop;
    kind      = $urandom_range(0, 2);
    pos       = $urandom_range(1, N - 1);
    threshold = 8'($urandom_range(0, 255));
    injected  = 0;
    stop      = 0;
    p         = 0;
    while (p < N && !stop) begin
      d = $urandom_range(0, 255);
      if (kind == 1 && p == pos) begin
        send_px(p, d, 0, 1);
        stop = 1;
      end else if (kind == 2 && p == pos && !injected) begin
        injected = 1;
        send_px(0, d, 1, 0);
        p = 1;
      end else begin
        send_px(p, d, p == 0, 0);
        p++;
      end
      if ($urandom_range(0, 7) == 0) threshold = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    if (stop) begin
      beat(11, 0, 0);
      if ($urandom_range(0, 1) == 1) det();
      idle(2);
    end else begin
      finish_frame();
    end
  endtask

  initial begin
    idle(3);
    do_reset();

    // Basic 4x3 ramp at threshold 128.
    full_frame(128);
    finish_frame();

    // Threshold dropped to 0 mid-frame must not matter.
    threshold = 8'd128;
    for (int p = 0; p < N; p++) begin
      if (p == 4) threshold = 8'd0;
      send_px(p, p * 20, p == 0, 0);
    end
    finish_frame();

    // eol at x=2 of line 1.
    threshold = 8'd100;
    for (int p = 0; p < 6; p++) send_px(p, p * 20, p == 0, 0);
    send_px(6, 120, 0, 1);
    beat(200, 0, 0);
    beat(10, 0, 1);
    idle(3);

    // sof on pixel 5 restarts the frame.
    threshold = 8'd60;
    for (int p = 0; p < 5; p++) send_px(p, p * 20, p == 0, 0);
    threshold = 8'd90;
    send_px(0, 100, 1, 0);
    for (int p = 1; p < N; p++) send_px(p, p * 20, 0, 0);
    finish_frame();

    // Non-sof beats in IDLE, then a clean frame.
    beat(250, 0, 0);
    beat(250, 0, 1);
    det();
    full_frame(50);
    finish_frame();

    // Reset mid-frame after pixel 6.
    threshold = 8'd128;
    for (int p = 0; p < 7; p++) send_px(p, p * 20, p == 0, 0);
    do_reset();
    full_frame(140);
    finish_frame();

    for (int i = 0; i < 25; i++) rand_frame();

    idle(4);
    chk("queue_drained", q_addr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
